// File: rtl/lcd_init_sequencer.sv
// HD44780 8-bit initialisation sequencer: after a power-on delay, plays ten latched
// instruction words onto the LCD bus with setup/E-pulse/hold timing and per-command waits.
module lcd_init_sequencer #(
  parameter int POWERON_CYC    = 1500000,
  parameter int SETUP_CYC      = 10,
  parameter int E_PULSE_CYC    = 50,
  parameter int HOLD_CYC       = 10,
  parameter int WAIT_SHORT_CYC = 4000,
  parameter int WAIT_LONG_CYC  = 164000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic [10:0] instruccion0,
  input  logic [10:0] instruccion1,
  input  logic [10:0] instruccion2,
  input  logic [10:0] instruccion3,
  input  logic [10:0] instruccion4,
  input  logic [10:0] instruccion5,
  input  logic [10:0] instruccion6,
  input  logic [10:0] instruccion7,
  input  logic [10:0] instruccion8,
  input  logic [10:0] instruccion9,
  output logic        DONE,
  output logic [10:0] salida
);

  localparam int MAX_CYC = (POWERON_CYC > WAIT_LONG_CYC) ? POWERON_CYC : WAIT_LONG_CYC;
  localparam int CNT_W   = ($clog2(MAX_CYC + 1) < 21) ? 21 : $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] PON_LAST   = CNT_W'(POWERON_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(E_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(WAIT_SHORT_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(WAIT_LONG_CYC - 1);

  typedef enum logic [2:0] {IDLE, POWERON, SETUP, PULSE, HOLD, WAIT, DONE_ST} state_t;

  state_t            state  = IDLE;
  state_t            state_n;
  logic [CNT_W-1:0]  cnt    = '0;
  logic [CNT_W-1:0]  cnt_n;
  logic [3:0]        step   = '0;
  logic [3:0]        step_n;
  logic              latch;
  logic [10:0]       salida_n;
  logic              done_n;
  logic [10:0]       words [10] = '{default: 11'd0};
  logic [10:0]       cur_w;
  logic [10:0]       nxt_w;
  logic              long_wait;

  assign cur_w = words[step];
  assign nxt_w = words[step_n];

  // Clear and return-home (DB 0x01..0x03 with RS=0) need the long execution time.
  assign long_wait = !cur_w[0] && (cur_w[10:3] >= 8'h01) && (cur_w[10:3] <= 8'h03);

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    step_n  = step;
    latch   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (init) begin
          state_n = POWERON;
          step_n  = '0;
          latch   = 1'b1;
        end
      end
      POWERON: if (cnt == PON_LAST)   begin state_n = SETUP; cnt_n = '0; end
      SETUP:   if (cnt == SETUP_LAST) begin state_n = PULSE; cnt_n = '0; end
      PULSE:   if (cnt == PULSE_LAST) begin state_n = HOLD;  cnt_n = '0; end
      HOLD:    if (cnt == HOLD_LAST)  begin state_n = WAIT;  cnt_n = '0; end
      WAIT: begin
        if (cnt == (long_wait ? LONG_LAST : SHORT_LAST)) begin
          cnt_n = '0;
          if (step == 4'd9) begin
            state_n = DONE_ST;
          end else begin
            step_n  = step + 4'd1;
            state_n = SETUP;
          end
        end
      end
      DONE_ST: begin
        cnt_n = '0;
        if (!init) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // Bus is registered from the next state so pins change cleanly with the state.
    salida_n = 11'd0;
    done_n   = (state_n == DONE_ST);
    unique case (state_n)
      IDLE, POWERON: salida_n = 11'd0;
      PULSE:         salida_n = nxt_w;
      default:       salida_n = {nxt_w[10:3], 1'b0, nxt_w[1:0]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      step   <= '0;
      salida <= 11'd0;
      DONE   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      step   <= step_n;
      salida <= salida_n;
      DONE   <= done_n;
    end
  end

  always_ff @(posedge clk) begin
    if (latch && !reset) begin
      words[0] <= instruccion0;
      words[1] <= instruccion1;
      words[2] <= instruccion2;
      words[3] <= instruccion3;
      words[4] <= instruccion4;
      words[5] <= instruccion5;
      words[6] <= instruccion6;
      words[7] <= instruccion7;
      words[8] <= instruccion8;
      words[9] <= instruccion9;
    end
  end

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Bench for lcd_init_sequencer: scaled-down timing, per-cycle comparison of {DONE, salida}
// against a timeline built directly from the sequencing rules.
module tb_lcd_init_sequencer;

  localparam int PON = 20;
  localparam int SET = 3;
  localparam int PUL = 4;
  localparam int HLD = 2;
  localparam int WS  = 10;
  localparam int WL  = 25;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init = 1'b0;
  logic [10:0] instr [10];
  logic        done;
  logic [10:0] salida;

  int total = 0;
  int passed = 0;

  logic [11:0] exp_q [$];
  logic [10:0] ref_w [10];

  always #5 clk = ~clk;

  lcd_init_sequencer #(
    .POWERON_CYC(PON), .SETUP_CYC(SET), .E_PULSE_CYC(PUL),
    .HOLD_CYC(HLD), .WAIT_SHORT_CYC(WS), .WAIT_LONG_CYC(WL)
  ) dut (
    .clk(clk), .reset(reset), .init(init),
    .instruccion0(instr[0]), .instruccion1(instr[1]), .instruccion2(instr[2]),
    .instruccion3(instr[3]), .instruccion4(instr[4]), .instruccion5(instr[5]),
    .instruccion6(instr[6]), .instruccion7(instr[7]), .instruccion8(instr[8]),
    .instruccion9(instr[9]),
    .DONE(done), .salida(salida)
  );

  function automatic int wait_len(input logic [10:0] w);
    if (w[0] == 1'b0 && w[10:3] >= 8'h01 && w[10:3] <= 8'h03) return WL;
    return WS;
  endfunction

  // Timeline of {DONE, salida}, one entry per cycle after the IDLE->POWERON edge.
  function automatic void build_trace();
    logic [10:0] off, on;
    exp_q.delete();
    for (int i = 0; i < PON; i++) exp_q.push_back(12'h000);
    for (int s = 0; s < 10; s++) begin
      off = ref_w[s] & ~11'h004;
      on  = ref_w[s];
      for (int i = 0; i < SET; i++) exp_q.push_back({1'b0, off});
      for (int i = 0; i < PUL; i++) exp_q.push_back({1'b0, on});
      for (int i = 0; i < HLD; i++) exp_q.push_back({1'b0, off});
      for (int i = 0; i < wait_len(ref_w[s]); i++) exp_q.push_back({1'b0, off});
    end
    exp_q.push_back({1'b1, ref_w[9] & ~11'h004});
  endfunction

  function automatic void load_spec_words();
    logic [10:0] sw [10] = '{11'h00C, 11'h014, 11'h07C, 11'h21D, 11'h295,
                             11'h24D, 11'h29D, 11'h2A5, 11'h24D, 11'h20D};
    for (int i = 0; i < 10; i++) begin
      instr[i] = sw[i];
      ref_w[i] = sw[i];
    end
  endfunction

  function automatic void load_random_words();
    logic [10:0] w;
    for (int i = 0; i < 10; i++) begin
      w = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 2) == 0) begin
        w[10:3] = 8'($urandom_range(1, 3));
        w[0]    = 1'b0;
      end
      w[2] = ($urandom_range(0, 3) != 0);
      instr[i] = w;
      ref_w[i] = w;
    end
  endfunction

  task automatic test_reset();
    init = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({done, salida} !== 12'h000)
        $display("FAIL reset_hold cyc%0d: got %h expected 000", i, {done, salida});
      else passed++;
    end
    init = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({done, salida} !== 12'h000)
        $display("FAIL idle_no_init cyc%0d: got %h expected 000", i, {done, salida});
      else passed++;
    end
  endtask

  task automatic test_full_run();
    logic [7:0] db_exp [10] = '{8'h01, 8'h02, 8'h0F, 8'h43, 8'h52,
                                8'h49, 8'h53, 8'h54, 8'h49, 8'h41};
    int npulse = 0;
    int dberr = 0;
    logic prev_e = 1'b0;
    load_spec_words();
    build_trace();
    init = 1'b1;
    foreach (exp_q[i]) begin
      @(negedge clk);
      total++;
      if ({done, salida} !== exp_q[i])
        $display("FAIL full_run cyc%0d: got %h expected %h", i, {done, salida}, exp_q[i]);
      else passed++;
      if (salida[2] && !prev_e) begin
        if (npulse < 10 && salida[10:3] !== db_exp[npulse]) dberr++;
        npulse++;
      end
      prev_e = salida[2];
    end
    total++;
    if (npulse !== 10) $display("FAIL e_pulse_count: got %0d expected 10", npulse);
    else passed++;
    total++;
    if (dberr !== 0) $display("FAIL e_pulse_db_seq: got %0d wrong expected 0", dberr);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({done, salida} !== {1'b1, ref_w[9] & ~11'h004})
        $display("FAIL done_hold cyc%0d: got %h expected %h", i, {done, salida},
                 {1'b1, ref_w[9] & ~11'h004});
      else passed++;
    end
    init = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({done, salida} !== 12'h000)
        $display("FAIL done_release cyc%0d: got %h expected 000", i, {done, salida});
      else passed++;
    end
  endtask

  task automatic test_e_en_off();
    load_random_words();
    instr[4] = 11'h218;
    ref_w[4] = 11'h218;
    instr[7] = 11'h00B;
    ref_w[7] = 11'h00B;
    build_trace();
    init = 1'b1;
    foreach (exp_q[i]) begin
      @(negedge clk);
      total++;
      if ({done, salida} !== exp_q[i])
        $display("FAIL e_en_off cyc%0d: got %h expected %h", i, {done, salida}, exp_q[i]);
      else passed++;
    end
    init = 1'b0;
    @(negedge clk);
    total++;
    if ({done, salida} !== 12'h000)
      $display("FAIL e_en_off_release: got %h expected 000", {done, salida});
    else passed++;
  endtask

  task automatic test_init_drop_word_change();
    for (int r = 0; r < 2; r++) begin
      load_random_words();
      build_trace();
      init = 1'b1;
      foreach (exp_q[i]) begin
        @(negedge clk);
        total++;
        if ({done, salida} !== exp_q[i])
          $display("FAIL init_drop r%0d cyc%0d: got %h expected %h", r, i, {done, salida}, exp_q[i]);
        else passed++;
        if (i == 10 + r * 60) begin
          init = 1'b0;
          for (int k = 0; k < 10; k++) instr[k] = 11'($urandom_range(0, 2047));
        end
      end
      // init is already low, so DONE lasts a single cycle before returning to IDLE.
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        total++;
        if ({done, salida} !== 12'h000)
          $display("FAIL init_drop_idle r%0d cyc%0d: got %h expected 000", r, i, {done, salida});
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    int hit;
    load_spec_words();
    build_trace();
    hit = PON;
    for (int s = 0; s < 3; s++) hit += SET + PUL + HLD + wait_len(ref_w[s]);
    hit += SET + 1;
    init = 1'b1;
    for (int i = 0; i <= hit; i++) begin
      @(negedge clk);
      total++;
      if ({done, salida} !== exp_q[i])
        $display("FAIL pre_reset cyc%0d: got %h expected %h", i, {done, salida}, exp_q[i]);
      else passed++;
    end
    total++;
    if (salida[2] !== 1'b1) $display("FAIL reset_in_pulse: got E=%b expected 1", salida[2]);
    else passed++;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({done, salida} !== 12'h000)
      $display("FAIL reset_mid_pulse: got %h expected 000", {done, salida});
    else passed++;
    reset = 1'b0;
    foreach (exp_q[i]) begin
      @(negedge clk);
      total++;
      if ({done, salida} !== exp_q[i])
        $display("FAIL restart cyc%0d: got %h expected %h", i, {done, salida}, exp_q[i]);
      else passed++;
    end
    init = 1'b0;
    @(negedge clk);
    total++;
    if ({done, salida} !== 12'h000)
      $display("FAIL restart_release: got %h expected 000", {done, salida});
    else passed++;
  endtask

  initial begin
    load_spec_words();
    repeat (3) @(posedge clk);
    test_reset();
    test_full_run();
    test_e_en_off();
    test_init_drop_word_change();
    test_reset_mid_pulse();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
